ref_clk_monitor: RTL
====================

// Module: ref_clk_monitor
// PURPOSE
//  Sits downstream of switch_clock and consumes its ClkStart. Qualifies the external PLL reference before the design
//  switches onto it: counts edges of a divided external-clock toggle inside fixed Clk_100M gate windows. Drives Ext_Sel
//  (1 = use External_PLL) only after GOOD_NEEDED consecutive in-tolerance windows. Falls back to the standard clock
//  after BAD_NEEDED consecutive bad windows.
// PARAMETERS
//  GATE_CYC     10000  gate window length in Clk_100M cycles (100 us)
//  EXP_CNT      1000   expected Ext_Clk_Tog rising edges per window
//  TOL          5      allowed |Meas_Cnt - EXP_CNT| for a pass (inclusive)
//  GOOD_NEEDED  4      consecutive passes required to select external clock
//  BAD_NEEDED   2      consecutive fails while locked to drop external clock
//  CNT_W        16     width of edge counter / Meas_Cnt
// PORTS
//  Clk_100M     in   1      system clock, all logic on rising edge
//  SYS_RST      in   1      synchronous, active-high reset
//  ClkStart     in   1      enable from switch_clock; low = monitor idle
//  Ext_Clk_Tog  in   1      external PLL divided toggle, asynchronous to Clk_100M
//  Ext_Sel      out  1      1 = external reference qualified and selected
//  Ref_Good     out  1      result of the most recent completed window (1 = pass)
//  Ref_Fault    out  1      sticky: set on any LOCKED->FAULT drop, cleared only by SYS_RST
//  Meas_Cnt     out  CNT_W  edge count of the last completed window
//  Meas_Valid   out  1      one-cycle pulse when Meas_Cnt/Ref_Good update
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, all counters 0. Reset wins over every other event.
//  Input path: 2-FF synchronizer, then a registered rising-edge detect. An Ext_Clk_Tog rise is counted 3 cycles later.
//   Ext_Clk_Tog high and low phases must each be >=2 Clk_100M cycles. Faster inputs are out of spec.
//  Gate: gate_cnt runs 0..GATE_CYC-1 with back-to-back windows and no gaps. The first window starts the cycle after
//   leaving IDLE. At gate_cnt==GATE_CYC-1:
//   - Meas_Cnt <= edge_cnt + edge (saturating at 2^CNT_W-1)
//   - edge_cnt <= 0
//   - Meas_Valid=1 on the next cycle, together with the new Meas_Cnt and Ref_Good.
//  Pass: (EXP_CNT-TOL) <= Meas_Cnt <= (EXP_CNT+TOL). Compare at CNT_W+1 bits, no underflow.
//  FSM (decisions are taken in the Meas_Valid cycle; state and Ext_Sel change on the following cycle):
//   IDLE   : Ext_Sel=0, counters held at 0. ClkStart=1 -> QUAL.
//   QUAL   : pass -> pass_cnt++. Fail -> pass_cnt=0. pass_cnt reaching GOOD_NEEDED -> LOCKED, Ext_Sel=1.
//   LOCKED : fail -> fail_cnt++. Pass -> fail_cnt=0. fail_cnt reaching BAD_NEEDED -> FAULT, Ext_Sel=0, Ref_Fault=1.
//   FAULT  : one cycle; clears pass_cnt/fail_cnt -> QUAL. Measurement windows continue uninterrupted.
//  ClkStart=0 in any state: next cycle IDLE.
//   - Ext_Sel=0, Ref_Good=0, gate/edge/pass/fail counters cleared.
//   - No Meas_Valid for the aborted partial window. Meas_Cnt and Ref_Fault hold.
//  ClkStart and a window end in the same cycle: ClkStart=0 wins, no Meas_Valid.
//  Ext_Sel changes only as stated above and never glitches. Downstream clock mux must be glitch-free.
// TESTING
//  1 Reset: SYS_RST=1 for 5 cycles with ClkStart=1 and Ext_Clk_Tog toggling -> all outputs 0, no Meas_Valid.
//  2 Lock: ClkStart=1, Ext_Clk_Tog period 10 cycles -> Meas_Valid every 10000 cycles with Meas_Cnt=1000, Ref_Good=1;
//    Ext_Sel rises the cycle after the 4th Meas_Valid; Ref_Fault stays 0.
//  3 Tolerance edges: force windows of 994/995/1005/1006 edges -> Ref_Good 0/1/1/0. In QUAL, one 994 window after
//    3 passes resets pass_cnt, so 4 further passes are needed.
//  4 Loss: locked, stop Ext_Clk_Tog -> two windows with Meas_Cnt=0; Ext_Sel falls after the 2nd Meas_Valid, Ref_Fault=1.
//    Restore the clock -> Ext_Sel=1 after 4 more passes; Ref_Fault stays 1.
//  5 Single bad window while locked: pass, fail (0 edges), pass -> Ext_Sel stays 1 throughout.
//  6 ClkStart=0 at gate_cnt=5000 -> next cycle IDLE, Ext_Sel=0, no Meas_Valid. Re-assert -> first Meas_Valid exactly
//    GATE_CYC+1 cycles later. Also pulse SYS_RST while LOCKED -> all outputs 0 next cycle, Ref_Fault cleared.

Source files
------------

// File: rtl/ref_clk_monitor_if.sv
// ref_clk_monitor_if: control and status bundle between switch_clock and the reference monitor
interface ref_clk_monitor_if #(parameter int CNT_W = 16);
  logic             ClkStart;
  logic             Ext_Clk_Tog;
  logic             Ext_Sel;
  logic             Ref_Good;
  logic             Ref_Fault;
  logic [CNT_W-1:0] Meas_Cnt;
  logic             Meas_Valid;
  modport master (output ClkStart, Ext_Clk_Tog, input Ext_Sel, Ref_Good, Ref_Fault, Meas_Cnt, Meas_Valid);
  modport slave  (input ClkStart, Ext_Clk_Tog, output Ext_Sel, Ref_Good, Ref_Fault, Meas_Cnt, Meas_Valid);
endinterface

// File: rtl/ref_clk_monitor.sv
// ref_clk_monitor: qualifies the external PLL reference by gated edge counting and drives Ext_Sel
module ref_clk_monitor #(
  parameter int GATE_CYC    = 10000,
  parameter int EXP_CNT     = 1000,
  parameter int TOL         = 5,
  parameter int GOOD_NEEDED = 4,
  parameter int BAD_NEEDED  = 2,
  parameter int CNT_W       = 16
) (
  input logic             Clk_100M,
  input logic             SYS_RST,
  ref_clk_monitor_if.slave bus
);
  localparam int GW = $clog2(GATE_CYC);
  localparam int LO = EXP_CNT > TOL ? EXP_CNT - TOL : 0;
  localparam int HI = EXP_CNT + TOL;
  typedef enum logic [1:0] {IDLE, QUAL, LOCKED, FAULT} state_t;
  state_t           r_state;
  logic             r_s1, r_s2, r_s3, r_edge;
  logic [GW-1:0]    r_gate;
  logic [CNT_W-1:0] r_edge_cnt, r_meas_cnt;
  logic             r_meas_valid, r_ref_good, r_ext_sel, r_ref_fault;
  logic [7:0]       r_pass, r_fail;
  logic [CNT_W:0]   w_sum;
  logic [CNT_W-1:0] w_sat;
  logic             w_pass, w_run, w_end;
  assign w_sum  = {1'b0, r_edge_cnt} + (CNT_W+1)'(r_edge);
  assign w_sat  = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
  assign w_pass = ({1'b0, w_sat} >= (CNT_W+1)'(LO)) && ({1'b0, w_sat} <= (CNT_W+1)'(HI));
  assign w_run  = bus.ClkStart && r_state != IDLE;
  assign w_end  = w_run && r_gate == GW'(GATE_CYC - 1);
  // Two-flop synchronizer for the asynchronous toggle, then a registered rising-edge detect
  always_ff @(posedge Clk_100M) begin
    if (SYS_RST) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_s3   <= 1'b0;
      r_edge <= 1'b0;
    end else begin
      r_s1   <= bus.Ext_Clk_Tog;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_edge <= r_s2 & ~r_s3;
    end
  end
  // Back-to-back gate windows; latch the saturated count and pass/fail at each window end
  always_ff @(posedge Clk_100M) begin
    if (SYS_RST) begin
      r_gate       <= '0;
      r_edge_cnt   <= '0;
      r_meas_cnt   <= '0;
      r_meas_valid <= 1'b0;
      r_ref_good   <= 1'b0;
    end else if (!w_run) begin
      r_gate       <= '0;
      r_edge_cnt   <= '0;
      r_meas_valid <= 1'b0;
      r_ref_good   <= bus.ClkStart & r_ref_good;
    end else begin
      r_gate       <= w_end ? '0 : r_gate + 1'b1;
      r_edge_cnt   <= w_end ? '0 : w_sat;
      r_meas_valid <= w_end;
      r_meas_cnt   <= w_end ? w_sat : r_meas_cnt;
      r_ref_good   <= w_end ? w_pass : r_ref_good;
    end
  end
  // Qualification FSM acting on each Meas_Valid; Ext_Sel is a registered FSM output so it cannot glitch
  always_ff @(posedge Clk_100M) begin
    if (SYS_RST) begin
      r_state     <= IDLE;
      r_ext_sel   <= 1'b0;
      r_ref_fault <= 1'b0;
      r_pass      <= '0;
      r_fail      <= '0;
    end else if (!bus.ClkStart) begin
      r_state   <= IDLE;
      r_ext_sel <= 1'b0;
      r_pass    <= '0;
      r_fail    <= '0;
    end else begin
      case (r_state)
        IDLE: r_state <= QUAL;
        QUAL: if (r_meas_valid) begin
          r_pass <= r_ref_good ? r_pass + 1'b1 : '0;
          if (r_ref_good && r_pass == 8'(GOOD_NEEDED - 1)) begin
            r_state   <= LOCKED;
            r_ext_sel <= 1'b1;
          end
        end
        LOCKED: if (r_meas_valid) begin
          r_fail <= r_ref_good ? '0 : r_fail + 1'b1;
          if (!r_ref_good && r_fail == 8'(BAD_NEEDED - 1)) begin
            r_state     <= FAULT;
            r_ext_sel   <= 1'b0;
            r_ref_fault <= 1'b1;
          end
        end
        default: begin
          r_pass  <= '0;
          r_fail  <= '0;
          r_state <= QUAL;
        end
      endcase
    end
  end
  assign bus.Ext_Sel    = r_ext_sel;
  assign bus.Ref_Good   = r_ref_good;
  assign bus.Ref_Fault  = r_ref_fault;
  assign bus.Meas_Cnt   = r_meas_cnt;
  assign bus.Meas_Valid = r_meas_valid;
endmodule
